shift_seq_unit: RTL and testbench
=================================

SHIFT_SEQ_UNIT -- requirements
Module: shift_seq_unit

Interface
REQ-001 Parameter WIDTH, default 8: data path width in bits, minimum 2.
REQ-002 Parameter AMT_W, default $clog2(WIDTH)+1: width of the shift-amount field.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request strobe; sampled in IDLE only.
REQ-006 op  input  3  operation: 000 HOLD, 001 SHL, 010 SHR, 011 CLR, 100 LOAD, 101 ROL, 110 ROR, 111 ASR.
REQ-007 amount  input  AMT_W  number of 1-bit steps for shift and rotate ops.
REQ-008 load_data  input  WIDTH  parallel value for LOAD.
REQ-009 Ir  input  1  serial fill bit for SHL, entering at bit 0.
REQ-010 Il  input  1  serial fill bit for SHR, entering at bit WIDTH-1.
REQ-011 q  output  WIDTH  register contents.
REQ-012 busy  output  1  high while the block is in SHIFT.
REQ-013 done  output  1  one-cycle completion pulse.
REQ-014 carry  output  1  last bit shifted or rotated out.
REQ-015 serialOutput1  output  1  equals q[WIDTH-1], combinational.
REQ-016 serialOutput2  output  1  equals q[0], combinational.

Function
REQ-017 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-018 The block SHALL accept a request at a rising edge in IDLE with start=1, and SHALL latch op, the saturated amount, Ir and Il at that edge.
REQ-019 On acceptance, an amount greater than WIDTH SHALL be treated as WIDTH.
REQ-020 HOLD SHALL leave q and carry unchanged, and the FSM SHALL go to DONE.
REQ-021 CLR SHALL set q=0 and carry=0 at the accept edge, and the FSM SHALL go to DONE.
REQ-022 LOAD SHALL set q=load_data and carry=0 at the accept edge, and the FSM SHALL go to DONE.
REQ-023 A shift or rotate op with amount 0 SHALL leave q and carry unchanged and SHALL go to DONE.
REQ-024 A shift or rotate op with amount N>0 SHALL go to SHIFT, load a down-counter with N, and perform exactly one 1-bit step per cycle on each of the N following edges.
REQ-025 SHL step: q={q[WIDTH-2:0],Ir}, carry=q[WIDTH-1].
REQ-026 SHR step: q={Il,q[WIDTH-1:1]}, carry=q[0].
REQ-027 ROL step: q={q[WIDTH-2:0],q[WIDTH-1]}, carry=q[WIDTH-1].
REQ-028 ROR step: q={q[0],q[WIDTH-1:1]}, carry=q[0].
REQ-029 ASR step: q={q[WIDTH-1],q[WIDTH-1:1]}, carry=q[0].
REQ-030 The FSM SHALL leave SHIFT for DONE on the edge that performs the Nth step.
REQ-031 busy SHALL be 1 exactly while the FSM is in SHIFT, i.e. for N cycles.
REQ-032 done SHALL be 1 exactly while the FSM is in DONE, for one cycle, and the FSM SHALL then return to IDLE unconditionally.
REQ-033 Request-to-done latency SHALL be 1 cycle for HOLD, CLR, LOAD and amount 0, and N+1 cycles otherwise.
REQ-034 start SHALL be ignored in SHIFT and DONE; requests made there SHALL NOT be queued.
REQ-035 Changes to op, amount, Ir, Il or load_data after the accept edge SHALL NOT affect the operation in progress.
REQ-036 q SHALL hold its value in IDLE and DONE.

Reset
REQ-037 rst_n=0 SHALL immediately force the FSM to IDLE, q=0, carry=0, busy=0 and done=0, regardless of clk and including in mid-SHIFT.
REQ-038 After rst_n rises, the first rising edge with start=1 SHALL be accepted normally.

Verification (WIDTH=8)
REQ-039 LOAD 0xA5, then SHL amount=3 with Ir=1 -> busy high 3 cycles; q=0x2F, carry=1; done pulses once, one cycle after the 3rd step.
REQ-040 LOAD 0x3C, then ROR amount=4 -> q=0xC3, carry=1; LOAD 0x90, then ASR amount=2 -> q=0xE4, carry=0.
REQ-041 LOAD 0xFF, then SHR amount=12 with Il=0 -> saturates to 8 steps (busy high 8 cycles); q=0x00, carry=1.
REQ-042 LOAD 0x81, SHL amount=5, assert start with op=CLR at the 2nd busy cycle -> CLR ignored; final q=0x20, carry=0.
REQ-043 Assert rst_n=0 between clock edges during a ROL amount=6 -> q=0, busy=0, done=0, carry=0 immediately, and no done pulse follows.
REQ-044 HOLD, and SHL with amount=0, applied to q=0x5A and carry=1 -> q and carry unchanged; done pulses 1 cycle after accept; busy stays 0.

Source files
------------

// File: rtl/shift_seq_unit.sv
// rtl/shift_seq_unit.sv - sequenced multi-step shift/rotate register with IDLE/SHIFT/DONE control
// One 1-bit step per cycle while in SHIFT; parallel ops complete at the accept edge.
module shift_seq_unit #(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [AMT_W-1:0] amount,
  input  logic [WIDTH-1:0] load_data,
  input  logic             Ir,
  input  logic             Il,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             carry,
  output logic             serialOutput1,
  output logic             serialOutput2
);

  localparam logic [2:0] OP_HOLD = 3'b000;
  localparam logic [2:0] OP_SHL  = 3'b001;
  localparam logic [2:0] OP_SHR  = 3'b010;
  localparam logic [2:0] OP_CLR  = 3'b011;
  localparam logic [2:0] OP_LOAD = 3'b100;
  localparam logic [2:0] OP_ROL  = 3'b101;
  localparam logic [2:0] OP_ROR  = 3'b110;
  localparam logic [2:0] OP_ASR  = 3'b111;

  localparam logic [AMT_W-1:0] AMT_MAX = AMT_W'(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             carry_q, carry_d;
  logic [2:0]       op_q, op_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic             ir_q, ir_d;
  logic             il_q, il_d;

  logic [AMT_W-1:0] amt_sat;
  logic [WIDTH-1:0] step_q;
  logic             step_c;

  assign amt_sat = (amount > AMT_MAX) ? AMT_MAX : amount;

  // Single-step result for the latched op; only consumed while in SHIFT.
  always_comb begin
    step_q = q_q;
    step_c = carry_q;
    unique case (op_q)
      OP_SHL: begin step_q = {q_q[WIDTH-2:0], ir_q};         step_c = q_q[WIDTH-1]; end
      OP_SHR: begin step_q = {il_q, q_q[WIDTH-1:1]};         step_c = q_q[0];       end
      OP_ROL: begin step_q = {q_q[WIDTH-2:0], q_q[WIDTH-1]}; step_c = q_q[WIDTH-1]; end
      OP_ROR: begin step_q = {q_q[0], q_q[WIDTH-1:1]};       step_c = q_q[0];       end
      OP_ASR: begin step_q = {q_q[WIDTH-1], q_q[WIDTH-1:1]}; step_c = q_q[0];       end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    carry_d = carry_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    ir_d    = ir_q;
    il_d    = il_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = op;
          ir_d    = Ir;
          il_d    = Il;
          cnt_d   = amt_sat;
          state_d = S_DONE;
          unique case (op)
            OP_HOLD: ;
            OP_CLR:  begin q_d = '0;        carry_d = 1'b0; end
            OP_LOAD: begin q_d = load_data; carry_d = 1'b0; end
            default: if (amt_sat != '0) state_d = S_SHIFT;
          endcase
        end
      end
      S_SHIFT: begin
        q_d     = step_q;
        carry_d = step_c;
        cnt_d   = cnt_q - 1'b1;
        if (cnt_q == AMT_W'(1)) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      q_q     <= '0;
      carry_q <= 1'b0;
      op_q    <= OP_HOLD;
      cnt_q   <= '0;
      ir_q    <= 1'b0;
      il_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      carry_q <= carry_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      ir_q    <= ir_d;
      il_q    <= il_d;
    end
  end

  assign q             = q_q;
  assign carry         = carry_q;
  assign busy          = (state_q == S_SHIFT);
  assign done          = (state_q == S_DONE);
  assign serialOutput1 = q_q[WIDTH-1];
  assign serialOutput2 = q_q[0];

endmodule

// File: tb/tb_shift_seq_unit.sv
// tb/tb_shift_seq_unit.sv - self-checking bench for shift_seq_unit against an arithmetic reference model
module tb_shift_seq_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [2:0] op;
  logic [3:0] amount;
  logic [7:0] load_data;
  logic       Ir, Il;
  logic [7:0] q;
  logic       busy, done, carry, so1, so2;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] m_q = 8'h00;
  logic       m_c = 1'b0;

  shift_seq_unit #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .amount(amount),
    .load_data(load_data), .Ir(Ir), .Il(Il), .q(q), .busy(busy), .done(done),
    .carry(carry), .serialOutput1(so1), .serialOutput2(so2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Whole-operation result computed with plain arithmetic: {carry, q}.
  function automatic logic [8:0] model(input logic [2:0] o, input int amt, input logic [7:0] qv,
                                       input logic cv, input logic [7:0] ld, input logic ir, input logic il);
    int n, k, qi, sq, r, c;
    n  = (amt > 8) ? 8 : amt;
    k  = n % 8;
    qi = int'(qv);
    r  = qi;
    c  = int'(cv);
    if (o == 3'd3) begin r = 0; c = 0; end
    else if (o == 3'd4) begin r = int'(ld); c = 0; end
    else if (o != 3'd0 && n > 0) begin
      case (o)
        3'd1: begin r = ((qi << n) | (ir ? ((1 << n) - 1) : 0)) & 255; c = (qi >> (8 - n)) & 1; end
        3'd2: begin r = (qi >> n) | (il ? (((1 << n) - 1) << (8 - n)) : 0); c = (qi >> (n - 1)) & 1; end
        3'd5: begin r = ((qi << k) | (qi >> (8 - k))) & 255; c = r & 1; end
        3'd6: begin r = ((qi >> k) | (qi << (8 - k))) & 255; c = (r >> 7) & 1; end
        default: begin
          sq = (qi >= 128) ? qi - 256 : qi;
          r  = (sq >>> n) & 255;
          c  = (qi >> (n - 1)) & 1;
        end
      endcase
    end
    return {c[0], r[7:0]};
  endfunction

  task automatic run_op(input string tag, input logic [2:0] o, input int amt, input logic [7:0] ld,
                        input logic ir, input logic il, input bit inject);
    logic [8:0] exp;
    int exp_busy, bc;
    exp      = model(o, amt, m_q, m_c, ld, ir, il);
    exp_busy = (o inside {3'd1, 3'd2, 3'd5, 3'd6, 3'd7}) ? ((amt > 8) ? 8 : amt) : 0;
    @(negedge clk);
    start = 1'b1; op = o; amount = amt[3:0]; load_data = ld; Ir = ir; Il = il;
    @(posedge clk); #1;
    start = 1'b0;
    op = 3'($urandom); amount = 4'($urandom); load_data = 8'($urandom);
    Ir = 1'($urandom); Il = 1'($urandom);
    bc = 0;
    while (busy === 1'b1 && bc < 40) begin
      bc++;
      if (inject && bc == 2) begin start = 1'b1; op = 3'd3; end
      else start = 1'b0;
      @(posedge clk); #1;
    end
    start = 1'b0;
    check({tag, " busy_cycles"}, bc, exp_busy);
    check({tag, " done"}, done, 1'b1);
    check({tag, " q"}, q, exp[7:0]);
    check({tag, " carry"}, carry, exp[8]);
    check({tag, " ser1"}, so1, exp[7]);
    check({tag, " ser0"}, so2, exp[0]);
    @(posedge clk); #1;
    check({tag, " done_once"}, {busy, done}, 2'b00);
    check({tag, " q_hold"}, q, exp[7:0]);
    m_q = exp[7:0];
    m_c = exp[8];
  endtask

  initial begin
    bit seen_done;
    rst_n = 1'b0; start = 1'b0; op = 3'd0; amount = 4'd0; load_data = 8'h00; Ir = 1'b0; Il = 1'b0;
    #2;
    check("reset outputs", {q, carry, busy, done}, 11'h000);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    run_op("load_a5", 3'd4, 0, 8'hA5, 1'b0, 1'b0, 1'b0);
    run_op("shl3", 3'd1, 3, 8'h00, 1'b1, 1'b0, 1'b0);
    check("shl3 literal", {carry, q}, 9'h12F);
    run_op("load_3c", 3'd4, 0, 8'h3C, 1'b0, 1'b0, 1'b0);
    run_op("ror4", 3'd6, 4, 8'h00, 1'b0, 1'b0, 1'b0);
    check("ror4 literal", {carry, q}, 9'h1C3);
    run_op("load_90", 3'd4, 0, 8'h90, 1'b0, 1'b0, 1'b0);
    run_op("asr2", 3'd7, 2, 8'h00, 1'b0, 1'b0, 1'b0);
    check("asr2 literal", {carry, q}, 9'h0E4);
    run_op("load_ff", 3'd4, 0, 8'hFF, 1'b0, 1'b0, 1'b0);
    run_op("shr12", 3'd2, 12, 8'h00, 1'b0, 1'b0, 1'b0);
    check("shr12 literal", {carry, q}, 9'h100);
    run_op("load_81", 3'd4, 0, 8'h81, 1'b0, 1'b0, 1'b0);
    run_op("shl5_inject", 3'd1, 5, 8'h00, 1'b0, 1'b0, 1'b1);
    check("shl5 literal", {carry, q}, 9'h020);
    run_op("load_b5", 3'd4, 0, 8'hB5, 1'b0, 1'b0, 1'b0);
    run_op("shr1", 3'd2, 1, 8'h00, 1'b0, 1'b0, 1'b0);
    check("5a carry set", {carry, q}, 9'h15A);
    run_op("hold", 3'd0, 7, 8'h00, 1'b0, 1'b0, 1'b0);
    run_op("shl0", 3'd1, 0, 8'h00, 1'b1, 1'b1, 1'b0);
    check("hold/shl0 literal", {carry, q}, 9'h15A);
    run_op("clr", 3'd3, 4, 8'hEE, 1'b1, 1'b1, 1'b0);

    run_op("load_c7", 3'd4, 0, 8'hC7, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b1; op = 3'd5; amount = 4'd6;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("async reset mid-shift", {q, carry, busy, done}, 11'h000);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    seen_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) seen_done = 1'b1;
    end
    check("no activity after reset", seen_done, 1'b0);
    m_q = 8'h00;
    m_c = 1'b0;
    run_op("first_after_reset", 3'd4, 0, 8'h6D, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      run_op("random", 3'($urandom_range(0, 7)), $urandom_range(0, 15), 8'($urandom),
             1'($urandom), 1'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
